// File: rtl/spi_ram_pkg.sv
// Shared types and helpers for the parametrised SPI-slave RAM controller.
package spi_ram_pkg;

   // Two-bit command tag carried in the top bits of each SPI word.
   typedef enum logic [1:0] {
      CMD_SET_WR = 2'b00,
      CMD_WRITE  = 2'b01,
      CMD_SET_RD = 2'b10,
      CMD_READ   = 2'b11
   } cmd_e;

   // Read-side state machine: FETCH covers the memory read pipeline,
   // HOLD presents the word until the consumer acknowledges it.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      HOLD  = 2'b10
   } rd_state_e;

   // Payload width is the wider of the address and data fields.
   function automatic int payload_w(input int aw, input int dw);
      return (aw > dw) ? aw : dw;
   endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// DEPTH x DATA_W storage: one write port, one synchronous read port and an
// optional extra output register. Words power up holding their own index.
module spi_ram_mem
   import spi_ram_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] words_s [DEPTH];
   logic [DATA_W-1:0] rd_q_r;

   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      logic [DATA_W-1:0] word_r = DATA_W'(g);

      // Storage word: overwritten only when addressed by the write port
      always_ff @(posedge clk) begin
         if (we && (waddr == ADDR_W'(g))) begin
            word_r <= wdata;
         end
      end

      assign words_s[g] = word_r;
   end

   // Synchronous read: captures the pre-write content, holds between reads
   always_ff @(posedge clk) begin
      if (re) begin
         rd_q_r <= words_s[raddr];
      end
   end

   if (RD_LAT == 2) begin : g_oreg
      logic [DATA_W-1:0] rd_q2_r;

      // Extra output stage for the two-cycle read latency
      always_ff @(posedge clk) begin
         rd_q2_r <= rd_q_r;
      end

      assign rdata = rd_q2_r;
   end else begin : g_noreg
      assign rdata = rd_q_r;
   end

endmodule

// File: rtl/spi_ram_ctrl_p.sv
// Command decoder, address registers, read handshake FSM and sticky flags
// sitting between the SPI slave shift logic and the storage array.
module spi_ram_ctrl_p
   import spi_ram_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   rx_valid,
   input  logic [payload_w(ADDR_W, DATA_W)+1:0]   din,
   input  logic                                   auto_inc,
   input  logic                                   tx_ack,
   input  logic                                   clr_flags,
   output logic [DATA_W-1:0]                      dout,
   output logic                                   tx_valid,
   output logic                                   addr_err,
   output logic                                   rd_ovf
);

   localparam int   P        = payload_w(ADDR_W, DATA_W);
   localparam int   AW1      = ADDR_W + 1;
   localparam logic LAT_INIT = (RD_LAT == 2) ? 1'b1 : 1'b0;

   cmd_e              cmd_s;
   logic [P-1:0]      payload_s;
   logic [ADDR_W-1:0] addr_pl_s;
   logic [ADDR_W-1:0] addr_mod_s;
   logic              addr_bad_s;
   logic              is_set_wr_s, is_write_s, is_set_rd_s, is_read_s;
   logic              rd_ok_s, rd_go_s, rd_drop_s, addr_err_set_s;
   logic [ADDR_W-1:0] wr_inc_s, rd_inc_s;
   logic [DATA_W-1:0] mem_rdata_s;

   rd_state_e         state_r;
   logic              lat_r;
   logic [ADDR_W-1:0] wr_addr_r, rd_addr_r;
   logic [DATA_W-1:0] dout_r;
   logic              tx_valid_r, addr_err_r, rd_ovf_r;

   // Command decode, range check and read-acceptance decision
   always_comb begin
      cmd_s          = cmd_e'(din[P+1:P]);
      payload_s      = din[P-1:0];
      addr_pl_s      = payload_s[ADDR_W-1:0];
      addr_bad_s     = ({1'b0, addr_pl_s} >= AW1'(DEPTH));
      addr_mod_s     = ADDR_W'({1'b0, addr_pl_s} % AW1'(DEPTH));
      is_set_wr_s    = rx_valid && (cmd_s == CMD_SET_WR);
      is_write_s     = rx_valid && (cmd_s == CMD_WRITE);
      is_set_rd_s    = rx_valid && (cmd_s == CMD_SET_RD);
      is_read_s      = rx_valid && (cmd_s == CMD_READ);
      rd_ok_s        = (state_r == IDLE) || ((state_r == HOLD) && tx_ack);
      rd_go_s        = is_read_s && rd_ok_s;
      rd_drop_s      = is_read_s && !rd_ok_s;
      addr_err_set_s = addr_bad_s && (is_set_wr_s || is_set_rd_s);
      wr_inc_s       = (wr_addr_r == ADDR_W'(DEPTH - 1)) ? {ADDR_W{1'b0}} : wr_addr_r + ADDR_W'(1);
      rd_inc_s       = (rd_addr_r == ADDR_W'(DEPTH - 1)) ? {ADDR_W{1'b0}} : rd_addr_r + ADDR_W'(1);
   end

   spi_ram_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
   ) u_mem (
      .clk   (clk),
      .we    (is_write_s),
      .waddr (wr_addr_r),
      .wdata (payload_s[DATA_W-1:0]),
      .re    (rd_go_s),
      .raddr (rd_addr_r),
      .rdata (mem_rdata_s)
   );

   // Address registers: loaded by SET commands (reduced modulo DEPTH), stepped by auto_inc
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr_r <= {ADDR_W{1'b0}};
         rd_addr_r <= {ADDR_W{1'b0}};
      end else begin
         if (is_set_wr_s) begin
            wr_addr_r <= addr_mod_s;
         end else if (is_write_s && auto_inc) begin
            wr_addr_r <= wr_inc_s;
         end
         if (is_set_rd_s) begin
            rd_addr_r <= addr_mod_s;
         end else if (rd_go_s && auto_inc) begin
            rd_addr_r <= rd_inc_s;
         end
      end
   end

   // Read handshake: wait out the memory latency, then hold dout until acknowledged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         lat_r      <= 1'b0;
         dout_r     <= {DATA_W{1'b0}};
         tx_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (rd_go_s) begin
                  state_r <= FETCH;
                  lat_r   <= LAT_INIT;
               end
            end
            FETCH: begin
               if (lat_r == 1'b0) begin
                  state_r    <= HOLD;
                  dout_r     <= mem_rdata_s;
                  tx_valid_r <= 1'b1;
               end else begin
                  lat_r <= 1'b0;
               end
            end
            HOLD: begin
               if (tx_ack) begin
                  tx_valid_r <= 1'b0;
                  if (rd_go_s) begin
                     state_r <= FETCH;
                     lat_r   <= LAT_INIT;
                  end else begin
                     state_r <= IDLE;
                  end
               end
            end
            default: begin
               state_r    <= IDLE;
               tx_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Sticky flags: a set event in the same cycle as clr_flags wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_err_r <= 1'b0;
         rd_ovf_r   <= 1'b0;
      end else begin
         addr_err_r <= addr_err_set_s ? 1'b1 : (clr_flags ? 1'b0 : addr_err_r);
         rd_ovf_r   <= rd_drop_s      ? 1'b1 : (clr_flags ? 1'b0 : rd_ovf_r);
      end
   end

   assign dout     = dout_r;
   assign tx_valid = tx_valid_r;
   assign addr_err = addr_err_r;
   assign rd_ovf   = rd_ovf_r;

endmodule

// File: tb/tb_spi_ram_ctrl_p.sv
// Bench for spi_ram_ctrl_p: instance A (DEPTH 256, RD_LAT 1) and instance B
// (DEPTH 200, RD_LAT 2) share stimulus, steered by sel_b.
module tb_spi_ram_ctrl_p;
   import spi_ram_pkg::*;

   typedef struct {
      logic       sel;
      cmd_e       cmd;
      logic [7:0] pl;
      logic       ai;
      logic [7:0] exp;
   } vec_t;

   logic       clk, rst, rx_valid, auto_inc, tx_ack, clr_flags, sel_b;
   logic [9:0] din;
   logic       rx_valid_a, rx_valid_b, tx_ack_a, tx_ack_b;
   logic [7:0] dout_a, dout_b, dout_v;
   logic       tx_valid_a, tx_valid_b, addr_err_a, addr_err_b, rd_ovf_a, rd_ovf_b;
   logic       tx_valid_v, rd_ovf_v, addr_err_v;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] sb_q [$];
   vec_t       vecs [16];

   assign rx_valid_a = rx_valid & ~sel_b;
   assign rx_valid_b = rx_valid & sel_b;
   assign tx_ack_a   = tx_ack & ~sel_b;
   assign tx_ack_b   = tx_ack & sel_b;
   assign dout_v     = sel_b ? dout_b : dout_a;
   assign tx_valid_v = sel_b ? tx_valid_b : tx_valid_a;
   assign rd_ovf_v   = sel_b ? rd_ovf_b : rd_ovf_a;
   assign addr_err_v = sel_b ? addr_err_b : addr_err_a;

   spi_ram_ctrl_p #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .RD_LAT(1)) u_a (
      .clk(clk), .rst(rst), .rx_valid(rx_valid_a), .din(din), .auto_inc(auto_inc),
      .tx_ack(tx_ack_a), .clr_flags(clr_flags), .dout(dout_a), .tx_valid(tx_valid_a),
      .addr_err(addr_err_a), .rd_ovf(rd_ovf_a)
   );

   spi_ram_ctrl_p #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .RD_LAT(2)) u_b (
      .clk(clk), .rst(rst), .rx_valid(rx_valid_b), .din(din), .auto_inc(auto_inc),
      .tx_ack(tx_ack_b), .clr_flags(clr_flags), .dout(dout_b), .tx_valid(tx_valid_b),
      .addr_err(addr_err_b), .rd_ovf(rd_ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One command word, presented for exactly one clock edge.
   task automatic send(input cmd_e cmd, input logic [7:0] pl);
      rx_valid = 1'b1;
      din      = {cmd, pl};
      @(posedge clk); #1;
      rx_valid = 1'b0;
      din      = 10'd0;
   endtask

   task automatic issue_read(input logic [7:0] exp);
      sb_q.push_back(exp);
      send(CMD_READ, 8'h00);
   endtask

   // Wait (bounded) for tx_valid, check latency since the READ edge, compare dout.
   task automatic wait_valid(input int exp_lat);
      int cnt = 0;
      logic [7:0] e;
      while (tx_valid_v !== 1'b1 && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("tx_valid_seen", {31'd0, tx_valid_v}, 32'd1);
      if (exp_lat > 0) chk("rd_latency", cnt, exp_lat);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("dout", {24'd0, dout_v}, {24'd0, e});
      end else begin
         chk("scoreboard_empty", sb_q.size(), 32'd1);
      end
   endtask

   task automatic ack();
      tx_ack = 1'b1;
      @(posedge clk); #1;
      tx_ack = 1'b0;
      chk("tx_valid_drop", {31'd0, tx_valid_v}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; din = 10'd0; auto_inc = 1'b0;
      tx_ack = 1'b0; clr_flags = 1'b0; sel_b = 1'b0;

      // sel, cmd, payload, auto_inc, expected read data
      vecs[0]  = '{1'b0, CMD_SET_RD, 8'h05, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, CMD_READ,   8'h00, 1'b0, 8'h05};
      vecs[2]  = '{1'b0, CMD_SET_WR, 8'hFE, 1'b1, 8'h00};
      vecs[3]  = '{1'b0, CMD_WRITE,  8'hAA, 1'b1, 8'h00};
      vecs[4]  = '{1'b0, CMD_WRITE,  8'hBB, 1'b1, 8'h00};
      vecs[5]  = '{1'b0, CMD_WRITE,  8'hCC, 1'b1, 8'h00};
      vecs[6]  = '{1'b0, CMD_SET_RD, 8'hFE, 1'b1, 8'h00};
      vecs[7]  = '{1'b0, CMD_READ,   8'h00, 1'b1, 8'hAA};
      vecs[8]  = '{1'b0, CMD_READ,   8'h00, 1'b1, 8'hBB};
      vecs[9]  = '{1'b0, CMD_READ,   8'h00, 1'b1, 8'hCC};
      vecs[10] = '{1'b0, CMD_READ,   8'h00, 1'b1, 8'h01};
      vecs[11] = '{1'b1, CMD_SET_RD, 8'h05, 1'b0, 8'h00};
      vecs[12] = '{1'b1, CMD_READ,   8'h00, 1'b0, 8'h05};
      vecs[13] = '{1'b1, CMD_SET_RD, 8'hC7, 1'b1, 8'h00};
      vecs[14] = '{1'b1, CMD_READ,   8'h00, 1'b1, 8'hC7};
      vecs[15] = '{1'b1, CMD_READ,   8'h00, 1'b1, 8'h00};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state of both instances
      chk("rst_dout_a", {24'd0, dout_a}, 32'd0);
      chk("rst_tx_valid_a", {31'd0, tx_valid_a}, 32'd0);
      chk("rst_addr_err_a", {31'd0, addr_err_a}, 32'd0);
      chk("rst_rd_ovf_a", {31'd0, rd_ovf_a}, 32'd0);
      chk("rst_tx_valid_b", {31'd0, tx_valid_b}, 32'd0);
      chk("rst_dout_b", {24'd0, dout_b}, 32'd0);

      // Table: power-up reads, write/readback with wrap, DEPTH-1 wrap on B
      for (int i = 0; i < 16; i++) begin
         sel_b    = vecs[i].sel;
         auto_inc = vecs[i].ai;
         if (vecs[i].cmd == CMD_READ) begin
            issue_read(vecs[i].exp);
            wait_valid(sel_b ? 2 : 1);
            ack();
         end else begin
            send(vecs[i].cmd, vecs[i].pl);
         end
      end
      chk("tbl_addr_err_b", {31'd0, addr_err_b}, 32'd0);
      chk("tbl_rd_ovf_a", {31'd0, rd_ovf_a}, 32'd0);

      // Hold and overrun on A
      sel_b = 1'b0; auto_inc = 1'b1;
      send(CMD_SET_RD, 8'h10);
      issue_read(8'h10);
      wait_valid(1);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) send(CMD_READ, 8'h00);
         else begin
            @(posedge clk); #1;
         end
         chk("hold_dout", {24'd0, dout_v}, 32'h10);
         chk("hold_tx_valid", {31'd0, tx_valid_v}, 32'd1);
      end
      chk("ovf_set", {31'd0, rd_ovf_v}, 32'd1);
      ack();
      issue_read(8'h11);
      wait_valid(1);
      ack();
      clr_flags = 1'b1;
      @(posedge clk); #1;
      clr_flags = 1'b0;
      chk("ovf_clr", {31'd0, rd_ovf_v}, 32'd0);

      // Back-to-back on A: READ in the same cycle as tx_ack
      send(CMD_SET_RD, 8'h20);
      issue_read(8'h20);
      wait_valid(1);
      tx_ack = 1'b1;
      issue_read(8'h21);
      tx_ack = 1'b0;
      chk("b2b_gap", {31'd0, tx_valid_v}, 32'd0);
      wait_valid(1);
      ack();
      chk("b2b_no_ovf", {31'd0, rd_ovf_v}, 32'd0);

      // Address error on B (DEPTH 200)
      sel_b = 1'b1; auto_inc = 1'b0;
      send(CMD_SET_WR, 8'hD0);
      chk("aerr_set", {31'd0, addr_err_v}, 32'd1);
      send(CMD_WRITE, 8'h5A);
      send(CMD_SET_RD, 8'h08);
      issue_read(8'h5A);
      wait_valid(2);
      ack();
      clr_flags = 1'b1;
      send(CMD_SET_RD, 8'hE0);
      clr_flags = 1'b0;
      chk("aerr_set_wins", {31'd0, addr_err_v}, 32'd1);
      issue_read(8'h18);
      wait_valid(2);
      ack();
      clr_flags = 1'b1;
      @(posedge clk); #1;
      clr_flags = 1'b0;
      chk("aerr_clr", {31'd0, addr_err_v}, 32'd0);

      // READ during FETCH on B is dropped and does not advance rd_addr
      auto_inc = 1'b1;
      send(CMD_SET_RD, 8'h03);
      issue_read(8'h03);
      send(CMD_READ, 8'h00);
      chk("fetch_ovf", {31'd0, rd_ovf_v}, 32'd1);
      wait_valid(-1);
      ack();
      issue_read(8'h04);
      wait_valid(2);
      ack();

      // Reset while A holds a word
      sel_b = 1'b0; auto_inc = 1'b0;
      send(CMD_SET_WR, 8'h30);
      send(CMD_WRITE, 8'h77);
      send(CMD_SET_RD, 8'h30);
      issue_read(8'h77);
      wait_valid(1);
      tx_ack = 1'b1;
      rst = 1'b1;
      #1;
      chk("rst_async_tx_valid", {31'd0, tx_valid_a}, 32'd0);
      chk("rst_async_dout", {24'd0, dout_a}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      tx_ack = 1'b0;
      chk("rst_ack_ignored", {31'd0, tx_valid_a}, 32'd0);
      issue_read(8'hCC);
      wait_valid(1);
      ack();
      send(CMD_SET_RD, 8'h30);
      issue_read(8'h77);
      wait_valid(1);
      ack();
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
